pipe_stage_reg: RTL

Parametrised pipeline stage register with valid/ready handshake, an optional skid entry, synchronous flush and bubble insertion. It is the generic successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. Each stage bundles its datapath fields into `in_data` and its side-effecting control bits (wreg, WMM, RMM, jal_jalr, …) into `in_ctrl`. Control bits are forced to zero whenever the stage holds a bubble, so a flushed or empty stage can never write a register or memory.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_sat_counter.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the generic pipeline stage register.
//   state_e : occupancy state of a stage. The encoding is chosen so that
//             the state value is also the number of held entries.
//   STAT_W  : width of the optional statistics counters.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  localparam int STAT_W = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter
// Free-running event counter that stops at its all-ones value instead of
// wrapping, so a long-running statistic never reads back as small.
// Ports:
//   clk   in  1  clock
//   rst   in  1  synchronous active-high reset, clears the count
//   inc   in  1  count one event this cycle
//   count out W  current count
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Generic pipeline stage register with valid/ready handshake. Datapath
// fields travel in in_data/out_data; side-effecting control bits travel in
// in_ctrl/out_ctrl and are forced to zero whenever the stage holds a bubble,
// so an empty or flushed stage can never write a register or memory.
//
// Parameters:
//   DATA_W  datapath payload width
//   CTRL_W  control payload width
//   SKID    1 = two-entry skid buffer, in_ready decoded from state only
//           0 = single register, in_ready = out_ready | !out_valid
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every held and incoming entry this cycle
//   in_valid/in_ready   upstream handshake
//   in_data/in_ctrl     upstream payload
//   out_valid/out_ready downstream handshake
//   out_data/out_ctrl   held payload (out_ctrl is 0 when out_valid is 0)
//   occupancy           number of held entries, 0..2
// Optional build macro PIPE_STAGE_STATS_EN adds:
//   stall_cnt  cycles with out_valid & !out_ready (saturating)
//   flush_cnt  cycles in which flush discarded a held valid entry (saturating)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_STATS_EN
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt,
`endif
  output logic [1:0]        occupancy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic xfer_in;
  logic xfer_out;

  assign out_valid = (state_q != ST_EMPTY);

  // With the skid entry, in_ready depends only on the state flop, which
  // breaks the combinational ready chain between neighbouring stages.
  assign in_ready = (SKID != 0) ? (state_q != ST_FULL) : (out_ready | ~out_valid);

  assign xfer_in  = in_valid & in_ready & ~flush;
  assign xfer_out = out_valid & out_ready;

  // Next-state and payload steering. Control bits of any slot that becomes
  // empty are cleared so stale control can never resurface.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Data registers keep their stale contents; only control is cleared.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (xfer_in) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (xfer_in && xfer_out) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (xfer_in) begin
            // Only reachable with SKID=1: without a skid, in_ready while
            // holding an entry implies the entry leaves this cycle.
            if (SKID != 0) begin
              state_d     = ST_FULL;
              skid_data_d = in_data;
              skid_ctrl_d = in_ctrl;
            end
          end else if (xfer_out) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the downstream side can move.
          if (xfer_out) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign out_data = main_data_q;
  // Belt and braces: the bubble rule holds even if a ctrl flop were stale.
  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  // The state encoding equals the entry count.
  assign occupancy = state_q;

`ifdef PIPE_STAGE_STATS_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = out_valid & ~out_ready;
  // A flush only discards something if an entry would otherwise remain:
  // FULL always keeps one, ONE keeps its entry unless it leaves this cycle.
  assign flush_inc = flush & ((state_q == ST_FULL) | ((state_q == ST_ONE) & ~out_ready));

  pipe_sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`endif

endmodule
